// File: rtl/mul_4x4_radix4_seq.sv
// Sequential 4x4 unsigned multiplier consuming the multiplier as two radix-4 digits.
// One operand pair in flight: IDLE -> DIG0 -> DIG1 -> DONE, product held on p until the next accept.
module mul_4x4_radix4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG0 = 2'd1,
        DIG1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] xr_q, xr_d;
    logic [3:0] yr_q, yr_d;
    logic [7:0] acc_q, acc_d;
    logic [5:0] pp_lo;
    logic [5:0] pp_hi;
    logic [7:0] acc_sum;

    // 4x2 AND-array: row1 is shifted one place and ripple-added onto row0[3:1].
    function automatic logic [5:0] pp_4x2(input logic [3:0] a, input logic [1:0] d);
        logic [3:0] row0;
        logic [3:0] row1;
        logic [5:0] res;
        logic       carry;
        logic       ai;
        row0   = a & {4{d[0]}};
        row1   = a & {4{d[1]}};
        res    = '0;
        res[0] = row0[0];
        carry  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ai         = (i < 3) ? row0[i+1] : 1'b0;
            res[i+1]   = ai ^ row1[i] ^ carry;
            carry      = (ai & row1[i]) | (ai & carry) | (row1[i] & carry);
        end
        res[5] = carry;
        return res;
    endfunction

    // The final sum never exceeds 225, so the carry out of bit 7 is always zero and dropped.
    function automatic logic [7:0] add_8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] sum;
        logic       carry;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        return sum;
    endfunction

    assign pp_lo   = pp_4x2(xr_q, yr_q[1:0]);
    assign pp_hi   = pp_4x2(xr_q, yr_q[3:2]);
    assign acc_sum = add_8(acc_q, {pp_hi, 2'b00});

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = x;
                    yr_d    = y;
                    acc_d   = '0;
                    state_d = DIG0;
                end
            end
            DIG0: begin
                acc_d   = {2'b00, pp_lo};
                state_d = DIG1;
            end
            DIG1: begin
                acc_d   = acc_sum;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = acc_q;

endmodule

// File: tb/tb_mul_4x4_radix4_seq.sv
// Scoreboard bench for mul_4x4_radix4_seq: accepted pairs are queued with their accept cycle,
// and a negedge monitor checks handshakes, latency, intermediate accumulator and held product.
module tb_mul_4x4_radix4_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x;
    logic [3:0] y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;

    typedef struct {
        int x;
        int y;
        int cyc;
    } txn_t;

    txn_t txn_q[$];
    int   hs_cyc[$];
    int   cyc;
    int   last_p;
    int   checks;
    int   errors;
    bit   rand_ready;

    mul_4x4_radix4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: the model only knows "a pair was accepted N cycles ago", never the DUT's state.
    always @(negedge clk) begin
        bit   was_empty;
        int   age;
        txn_t t;
        if (rst) begin
            txn_q.delete();
            last_p = 0;
        end else begin
            was_empty = (txn_q.size() == 0);
            check_output("in_ready", int'(in_ready), int'(was_empty));
            if (was_empty) begin
                check_output("idle_out_valid", int'(out_valid), 0);
                check_output("idle_p_hold", int'(p), last_p);
            end else begin
                t   = txn_q[0];
                age = cyc - t.cyc;
                if (age == 1) begin
                    check_output("dig0_out_valid", int'(out_valid), 0);
                    check_output("acc_cleared", int'(p), 0);
                end else if (age == 2) begin
                    check_output("dig1_out_valid", int'(out_valid), 0);
                    check_output("acc_low_digit", int'(p), t.x * (t.y % 4));
                end else begin
                    check_output("done_out_valid", int'(out_valid), 1);
                    check_output("product", int'(p), t.x * t.y);
                    if (out_ready) begin
                        last_p = t.x * t.y;
                        hs_cyc.push_back(cyc);
                        void'(txn_q.pop_front());
                    end
                end
            end
            if (was_empty && in_valid) begin
                t.x   = int'(x);
                t.y   = int'(y);
                t.cyc = cyc;
                txn_q.push_back(t);
            end
        end
        cyc++;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom % 2);
        end
    end

    task automatic apply_stimulus(input logic [3:0] xa, input logic [3:0] ya, input bit keep);
        int n;
        n        = 0;
        x        = xa;
        y        = ya;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_output("accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        x = 4'($urandom);
        y = 4'($urandom);
        if (!keep) begin
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (txn_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_output("drain_timeout", txn_q.size(), 0);
    endtask

    initial begin
        cyc        = 0;
        last_p     = 0;
        checks     = 0;
        errors     = 0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        x          = 4'd5;
        y          = 4'd5;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_output("reset_in_ready", int'(in_ready), 1);
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_p", int'(p), 0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        apply_stimulus(4'd15, 4'd15, 1'b0);
        drain();
        apply_stimulus(4'd13, 4'd6, 1'b0);
        drain();
        apply_stimulus(4'd9, 4'd0, 1'b0);
        drain();
        apply_stimulus(4'd0, 4'd11, 1'b0);
        drain();

        // Consumer stalls for several cycles in DONE.
        out_ready = 1'b0;
        apply_stimulus(4'd7, 4'd12, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset lands while the pair is in DIG1.
        apply_stimulus(4'd11, 4'd9, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("midreset_in_ready", int'(in_ready), 1);
        check_output("midreset_out_valid", int'(out_valid), 0);
        check_output("midreset_p", int'(p), 0);
        repeat (6) @(posedge clk);
        #1;

        hs_cyc.delete();
        apply_stimulus(4'd3, 4'd5, 1'b1);
        apply_stimulus(4'd15, 4'd1, 1'b1);
        apply_stimulus(4'd2, 4'd14, 1'b0);
        drain();
        check_output("throughput_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check_output("throughput_gap1", hs_cyc[1] - hs_cyc[0], 4);
            check_output("throughput_gap2", hs_cyc[2] - hs_cyc[1], 4);
        end

        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            apply_stimulus(4'(i / 16), 4'(i % 16), 1'b0);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
